// File: rtl/dsp_pkg.sv
// Shared encodings for the DSP48A1-style MAC slice.
package dsp_pkg;

    typedef enum logic [1:0] {
        X_ZERO = 2'd0,
        X_M    = 2'd1,
        X_P    = 2'd2,
        X_DAB  = 2'd3
    } xsel_e;

    typedef enum logic [1:0] {
        Z_ZERO = 2'd0,
        Z_PCIN = 2'd1,
        Z_P    = 2'd2,
        Z_C    = 2'd3
    } zsel_e;

    localparam int OP_X_LSB   = 0;
    localparam int OP_Z_LSB   = 2;
    localparam int OP_B1SEL   = 4;
    localparam int OP_CIN     = 5;
    localparam int OP_PRESUB  = 6;
    localparam int OP_POSTSUB = 7;

    localparam string CIN_OPMODE5 = "OPMODE5";
    localparam string CIN_PIN     = "CARRYIN";
    localparam string BIN_DIRECT  = "DIRECT";
    localparam string BIN_CASCADE = "CASCADE";

endpackage

// File: rtl/dsp_reg_mux.sv
// One pipeline stage: a CE/sync-reset register, or a plain wire.
module dsp_reg_mux #(
    parameter int WIDTH = 18,
    parameter int REG   = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ce,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (REG != 0) begin : g_reg
            logic [WIDTH-1:0] r_q;
            always_ff @(posedge i_clk) begin
                if (i_rst)
                    r_q <= '0;
                else if (i_ce)
                    r_q <= i_d;
            end
            assign o_q = r_q;
        end else begin : g_wire
            logic w_unused;
            assign w_unused = ^{i_clk, i_rst, i_ce};
            assign o_q = i_d;
        end
    endgenerate

endmodule

// File: rtl/dsp.sv
// Pipelined 18x18 pre-add/multiply/post-add slice with B and P cascade.
module dsp
    import dsp_pkg::*;
#(
    parameter int    A0REG       = 0,
    parameter int    A1REG       = 1,
    parameter int    B0REG       = 0,
    parameter int    B1REG       = 1,
    parameter int    CREG        = 1,
    parameter int    DREG        = 1,
    parameter int    MREG        = 1,
    parameter int    PREG        = 1,
    parameter int    OPMODEREG   = 1,
    parameter int    CARRYINREG  = 1,
    parameter int    CARRYOUTREG = 1,
    parameter string CARRYINSEL  = "OPMODE5",
    parameter string B_INPUT     = "DIRECT"
) (
    input  logic        CEP,
    input  logic        RSTP,
    output logic        CARRYOUT,
    output logic        CARRYOUTF,
    output logic [35:0] M,
    output logic [47:0] P,
    input  logic        RSTCARRYIN,
    output logic [17:0] BCOUT,
    input  logic        CECARRYIN,
    input  logic [47:0] PCIN,
    output logic [47:0] PCOUT,
    input  logic        CARRYIN,
    input  logic        RSTM,
    input  logic        CEM,
    input  logic [7:0]  OPMODE,
    input  logic        CEOPMODE,
    input  logic        RSTOPMODE,
    input  logic [17:0] A,
    input  logic [17:0] B,
    input  logic [47:0] C,
    input  logic [17:0] D,
    input  logic [17:0] BCIN,
    input  logic        CLK,
    input  logic        RSTA,
    input  logic        RSTB,
    input  logic        RSTC,
    input  logic        RSTD,
    input  logic        CEA,
    input  logic        CEB,
    input  logic        CEC,
    input  logic        CED
);

    localparam bit CIN_FROM_PIN = (CARRYINSEL == CIN_PIN);
    localparam bit B_FROM_CASC  = (B_INPUT == BIN_CASCADE);

    logic [17:0] w_a0, w_a1, w_b_src, w_b0, w_b1_d, w_b1, w_d, w_pre;
    logic [47:0] w_c, w_p, w_x, w_z;
    logic [35:0] w_mult, w_m;
    logic [7:0]  w_op;
    logic        w_cin_src, w_cin, w_co;
    logic [48:0] w_xc, w_post;

    dsp_reg_mux #(.WIDTH(18), .REG(A0REG)) u_a0 (
        .i_clk(CLK), .i_rst(RSTA), .i_ce(CEA), .i_d(A), .o_q(w_a0));
    dsp_reg_mux #(.WIDTH(18), .REG(A1REG)) u_a1 (
        .i_clk(CLK), .i_rst(RSTA), .i_ce(CEA), .i_d(w_a0), .o_q(w_a1));

    assign w_b_src = B_FROM_CASC ? BCIN : B;
    dsp_reg_mux #(.WIDTH(18), .REG(B0REG)) u_b0 (
        .i_clk(CLK), .i_rst(RSTB), .i_ce(CEB), .i_d(w_b_src), .o_q(w_b0));
    dsp_reg_mux #(.WIDTH(18), .REG(DREG)) u_d (
        .i_clk(CLK), .i_rst(RSTD), .i_ce(CED), .i_d(D), .o_q(w_d));
    dsp_reg_mux #(.WIDTH(48), .REG(CREG)) u_c (
        .i_clk(CLK), .i_rst(RSTC), .i_ce(CEC), .i_d(C), .o_q(w_c));
    dsp_reg_mux #(.WIDTH(8), .REG(OPMODEREG)) u_op (
        .i_clk(CLK), .i_rst(RSTOPMODE), .i_ce(CEOPMODE),
        .i_d(OPMODE), .o_q(w_op));

    // Pre-adder wraps at 18 bits; B1 picks raw B0 or the pre-adder.
    assign w_pre  = w_op[OP_PRESUB] ? (w_d - w_b0) : (w_d + w_b0);
    assign w_b1_d = w_op[OP_B1SEL] ? w_pre : w_b0;
    dsp_reg_mux #(.WIDTH(18), .REG(B1REG)) u_b1 (
        .i_clk(CLK), .i_rst(RSTB), .i_ce(CEB), .i_d(w_b1_d), .o_q(w_b1));

    assign w_mult = 36'(w_a1) * 36'(w_b1);
    dsp_reg_mux #(.WIDTH(36), .REG(MREG)) u_m (
        .i_clk(CLK), .i_rst(RSTM), .i_ce(CEM), .i_d(w_mult), .o_q(w_m));

    assign w_cin_src = CIN_FROM_PIN ? CARRYIN : w_op[OP_CIN];
    dsp_reg_mux #(.WIDTH(1), .REG(CARRYINREG)) u_cin (
        .i_clk(CLK), .i_rst(RSTCARRYIN), .i_ce(CECARRYIN),
        .i_d(w_cin_src), .o_q(w_cin));

    always_comb begin
        w_x = '0;
        unique case (xsel_e'(w_op[OP_X_LSB +: 2]))
            X_ZERO: w_x = '0;
            X_M:    w_x = {12'd0, w_m};
            X_P:    w_x = w_p;
            X_DAB:  w_x = {w_d[11:0], w_a1, w_b1};
        endcase
    end

    always_comb begin
        w_z = '0;
        unique case (zsel_e'(w_op[OP_Z_LSB +: 2]))
            Z_ZERO: w_z = '0;
            Z_PCIN: w_z = PCIN;
            Z_P:    w_z = w_p;
            Z_C:    w_z = w_c;
        endcase
    end

    // Bit 48 is the carry on add and the borrow on subtract.
    assign w_xc   = {1'b0, w_x} + 49'(w_cin);
    assign w_post = w_op[OP_POSTSUB] ? ({1'b0, w_z} - w_xc)
                                     : ({1'b0, w_z} + w_xc);

    dsp_reg_mux #(.WIDTH(48), .REG(PREG)) u_p (
        .i_clk(CLK), .i_rst(RSTP), .i_ce(CEP),
        .i_d(w_post[47:0]), .o_q(w_p));
    dsp_reg_mux #(.WIDTH(1), .REG(CARRYOUTREG)) u_co (
        .i_clk(CLK), .i_rst(RSTP), .i_ce(CEP),
        .i_d(w_post[48]), .o_q(w_co));

    assign BCOUT     = w_b1;
    assign M         = w_m;
    assign P         = w_p;
    assign PCOUT     = w_p;
    assign CARRYOUT  = w_co;
    assign CARRYOUTF = w_co;

endmodule

// File: tb/tb_dsp.sv
// Bench for dsp: directed MAC scenarios plus random traffic vs a cycle model.
module tb_dsp;

    logic        CLK;
    logic        CEP, RSTP, RSTCARRYIN, CECARRYIN, CARRYIN, RSTM, CEM;
    logic        CEOPMODE, RSTOPMODE, RSTA, RSTB, RSTC, RSTD;
    logic        CEA, CEB, CEC, CED;
    logic [7:0]  OPMODE;
    logic [17:0] A, B, D, BCIN, BCOUT;
    logic [47:0] C, PCIN, P, PCOUT;
    logic [35:0] M;
    logic        CARRYOUT, CARRYOUTF;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [63:0] M18 = 64'h3_FFFF;
    localparam logic [63:0] M48 = 64'hFFFF_FFFF_FFFF;

    // Reference state: value held by each registered stage.
    logic [63:0] m_a1, m_b1, m_d, m_c, m_op, m_cin, m_m, m_p, m_co;

    dsp u_dut (
        .CEP(CEP), .RSTP(RSTP), .CARRYOUT(CARRYOUT),
        .CARRYOUTF(CARRYOUTF), .M(M), .P(P),
        .RSTCARRYIN(RSTCARRYIN), .BCOUT(BCOUT),
        .CECARRYIN(CECARRYIN), .PCIN(PCIN), .PCOUT(PCOUT),
        .CARRYIN(CARRYIN), .RSTM(RSTM), .CEM(CEM),
        .OPMODE(OPMODE), .CEOPMODE(CEOPMODE),
        .RSTOPMODE(RSTOPMODE), .A(A), .B(B), .C(C), .D(D),
        .BCIN(BCIN), .CLK(CLK), .RSTA(RSTA), .RSTB(RSTB),
        .RSTC(RSTC), .RSTD(RSTD), .CEA(CEA), .CEB(CEB),
        .CEC(CEC), .CED(CED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        logic [63:0] b0, pre, b1n, mul, x, z, s, cin_src;
        b0      = 64'(B);
        pre     = m_op[6] ? ((m_d - b0) & M18) : ((m_d + b0) & M18);
        b1n     = m_op[4] ? pre : b0;
        mul     = m_a1 * m_b1;
        cin_src = 64'(m_op[5]);
        case (m_op & 64'd3)
            64'd0:   x = 0;
            64'd1:   x = m_m;
            64'd2:   x = m_p;
            default: x = ((m_d & 64'hFFF) << 36) | (m_a1 << 18) | m_b1;
        endcase
        case ((m_op >> 2) & 64'd3)
            64'd0:   z = 0;
            64'd1:   z = 64'(PCIN);
            64'd2:   z = m_p;
            default: z = m_c;
        endcase
        s = m_op[7] ? (z - (x + m_cin)) : (z + x + m_cin);
        if (RSTA) m_a1 = 0; else if (CEA) m_a1 = 64'(A);
        if (RSTB) m_b1 = 0; else if (CEB) m_b1 = b1n;
        if (RSTD) m_d = 0; else if (CED) m_d = 64'(D);
        if (RSTC) m_c = 0; else if (CEC) m_c = 64'(C);
        if (RSTOPMODE) m_op = 0;
        else if (CEOPMODE) m_op = 64'(OPMODE);
        if (RSTCARRYIN) m_cin = 0;
        else if (CECARRYIN) m_cin = cin_src;
        if (RSTM) m_m = 0; else if (CEM) m_m = mul;
        if (RSTP) begin
            m_p  = 0;
            m_co = 0;
        end else if (CEP) begin
            m_p  = s & M48;
            m_co = (s >> 48) & 64'd1;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        chk("P", 64'(P), m_p);
        chk("PCOUT", 64'(PCOUT), m_p);
        chk("M", 64'(M), m_m);
        chk("BCOUT", 64'(BCOUT), m_b1);
        chk("CARRYOUT", 64'(CARRYOUT), m_co);
        chk("CARRYOUTF", 64'(CARRYOUTF), m_co);
    endtask

    task automatic set_rst(input logic v);
        RSTA = v; RSTB = v; RSTC = v; RSTD = v;
        RSTM = v; RSTP = v; RSTCARRYIN = v; RSTOPMODE = v;
    endtask

    task automatic set_ce(input logic v);
        CEA = v; CEB = v; CEC = v; CED = v;
        CEM = v; CEP = v; CECARRYIN = v; CEOPMODE = v;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [63:0] prev;

    initial begin
        {m_a1, m_b1, m_d, m_c, m_op, m_cin, m_m, m_p, m_co} = '0;
        A = 0; B = 0; D = 0; BCIN = 0; C = 0; PCIN = 0;
        CARRYIN = 0; OPMODE = 0;
        set_ce(1'b1);
        set_rst(1'b1);
        ticks(5);
        chk("rst_P", 64'(P), 64'd0);
        chk("rst_M", 64'(M), 64'd0);
        chk("rst_BCOUT", 64'(BCOUT), 64'd0);
        chk("rst_PCOUT", 64'(PCOUT), 64'd0);
        chk("rst_CO", 64'(CARRYOUT), 64'd0);
        set_rst(1'b0);

        OPMODE = 8'h03; A = 1; B = 1; D = 1;
        C = 1; PCIN = 1; CARRYIN = 1;
        ticks(8);
        chk("cat_P", 64'(P), 64'h10_0004_0001);
        chk("cat_CO", 64'(CARRYOUT), 64'd0);

        A = 135; B = 35; D = 35; OPMODE = 8'h58;
        ticks(8);
        chk("hold_P", 64'(P), 64'h10_0004_0001);

        A = 7; B = 4; D = 3; C = 49; OPMODE = 8'h9D;
        ticks(8);
        chk("msub_M", 64'(M), 64'd49);
        chk("msub_P", 64'(P), 64'd0);
        chk("msub_CO", 64'(CARRYOUT), 64'd0);

        OPMODE = 8'h09; A = 2; B = 3;
        ticks(6);
        for (int i = 0; i < 5; i++) begin
            prev = 64'(P);
            tick();
            chk("acc_P", 64'(P), (prev + 64'd6) & M48);
        end
        CEP = 0;
        prev = 64'(P);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_P", 64'(P), prev);
        end
        CEP = 1; RSTP = 1;
        tick();
        chk("rstp_P", 64'(P), 64'd0);
        RSTP = 0;

        OPMODE = 8'h2C; C = 48'hFFFF_FFFF_FFFF;
        ticks(4);
        chk("cy_P", 64'(P), 64'd0);
        chk("cy_CO", 64'(CARRYOUT), 64'd1);
        chk("cy_COF", 64'(CARRYOUTF), 64'd1);

        for (int i = 0; i < 400; i++) begin
            A = 18'($urandom); B = 18'($urandom); D = 18'($urandom);
            BCIN = 18'($urandom); CARRYIN = 1'($urandom);
            C = 48'({$urandom(), $urandom()});
            PCIN = 48'({$urandom(), $urandom()});
            if ($urandom_range(0, 3) == 0) OPMODE = 8'($urandom);
            CEA = ($urandom_range(0, 9) != 0);
            CEB = ($urandom_range(0, 9) != 0);
            CEC = ($urandom_range(0, 9) != 0);
            CED = ($urandom_range(0, 9) != 0);
            CEM = ($urandom_range(0, 9) != 0);
            CEP = ($urandom_range(0, 9) != 0);
            CECARRYIN = ($urandom_range(0, 9) != 0);
            CEOPMODE = ($urandom_range(0, 9) != 0);
            RSTA = ($urandom_range(0, 39) == 0);
            RSTB = ($urandom_range(0, 39) == 0);
            RSTC = ($urandom_range(0, 39) == 0);
            RSTD = ($urandom_range(0, 39) == 0);
            RSTM = ($urandom_range(0, 39) == 0);
            RSTP = ($urandom_range(0, 39) == 0);
            RSTCARRYIN = ($urandom_range(0, 39) == 0);
            RSTOPMODE = ($urandom_range(0, 39) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
